// File: rtl/vector_reg_file_if.sv
// vector_reg_file_if: request and response bundle between issue logic and the vector register file.
interface vector_reg_file_if #(
   parameter int READ_PORTS      = 4,
   parameter int WRITE_PORTS     = 4,
   parameter int VSEL_W          = 8,
   parameter int VREG_W          = 512,
   parameter int MASK_BANK_COUNT = 2,
   parameter int MSEL_W          = 4,
   parameter int VLMAX           = 32
);
   logic [READ_PORTS-1:0][VSEL_W-1:0]      vs;
   logic [READ_PORTS-1:0]                  REN;
   logic [WRITE_PORTS-1:0][VSEL_W-1:0]     vd;
   logic [WRITE_PORTS-1:0][VREG_W-1:0]     vdata;
   logic [WRITE_PORTS-1:0]                 WEN;
   logic [MASK_BANK_COUNT-1:0][MSEL_W-1:0] vms;
   logic [MASK_BANK_COUNT-1:0]             MREN;
   logic [MASK_BANK_COUNT-1:0][MSEL_W-1:0] vmd;
   logic [MASK_BANK_COUNT-1:0][VLMAX-1:0]  mvdata;
   logic [MASK_BANK_COUNT-1:0]             MWEN;
   logic                                   iready;
   logic                                   accomplished;
   logic [MASK_BANK_COUNT-1:0]             ivalid;
   logic [READ_PORTS-1:0][VREG_W-1:0]      vreg;
   logic [MASK_BANK_COUNT-1:0][VLMAX-1:0]  vmask;
   modport master (
      output vs, REN, vd, vdata, WEN, vms, MREN, vmd, mvdata, MWEN, iready, accomplished,
      input  ivalid, vreg, vmask
   );
   modport slave (
      input  vs, REN, vd, vdata, WEN, vms, MREN, vmd, mvdata, MWEN, iready, accomplished,
      output ivalid, vreg, vmask
   );
endinterface

// File: rtl/vector_reg_file.sv
// vector_reg_file: banked vector/mask register file with fixed-priority bank scheduling and an operand buffer.
module vector_reg_file #(
   parameter int READ_PORTS      = 4,
   parameter int WRITE_PORTS     = 4,
   parameter int NUM_VREGS       = 256,
   parameter int BANK_COUNT      = 4,
   parameter int VLMAX           = 32,
   parameter int ELEN            = 16,
   parameter int NUM_MASKS       = 16,
   parameter int MASK_BANK_COUNT = 2
) (
   input logic              CLK,
   input logic              nRST,
   vector_reg_file_if.slave bus
);
   localparam int VREG_W  = VLMAX * ELEN;
   localparam int BANK_W  = $clog2(BANK_COUNT);
   localparam int MBANK_W = $clog2(MASK_BANK_COUNT);

   logic [VREG_W-1:0]                     vregs [NUM_VREGS];
   logic [VLMAX-1:0]                      masks [NUM_MASKS];
   logic [WRITE_PORTS-1:0]                wdone, wgnt;
   logic [READ_PORTS-1:0]                 rdone, rgnt, stage_v, slot_v;
   logic [MASK_BANK_COUNT-1:0]            mwdone, mwgnt, mrdone, mrgnt, mstage_v, mslot_v, grp_ready;
   logic [READ_PORTS-1:0][VREG_W-1:0]     stage, slot;
   logic [MASK_BANK_COUNT-1:0][VLMAX-1:0] mstage, mslot;

   // a port is granted unless a lower-index pending port targets the same bank
   always_comb begin
      wgnt = '0;
      rgnt = '0;
      mwgnt = '0;
      mrgnt = '0;
      for (int p = 0; p < WRITE_PORTS; p++) begin
         wgnt[p] = bus.WEN[p] && !wdone[p];
         for (int q = 0; q < p; q++)
            if (bus.WEN[q] && !wdone[q] && bus.vd[q][BANK_W-1:0] == bus.vd[p][BANK_W-1:0]) wgnt[p] = 1'b0;
      end
      for (int p = 0; p < READ_PORTS; p++) begin
         rgnt[p] = bus.REN[p] && !rdone[p] && !bus.accomplished;
         for (int q = 0; q < p; q++)
            if (bus.REN[q] && !rdone[q] && bus.vs[q][BANK_W-1:0] == bus.vs[p][BANK_W-1:0]) rgnt[p] = 1'b0;
      end
      for (int p = 0; p < MASK_BANK_COUNT; p++) begin
         mwgnt[p] = bus.MWEN[p] && !mwdone[p];
         mrgnt[p] = bus.MREN[p] && !mrdone[p] && !bus.accomplished;
         for (int q = 0; q < p; q++) begin
            if (bus.MWEN[q] && !mwdone[q] && bus.vmd[q][MBANK_W-1:0] == bus.vmd[p][MBANK_W-1:0]) mwgnt[p] = 1'b0;
            if (bus.MREN[q] && !mrdone[q] && bus.vms[q][MBANK_W-1:0] == bus.vms[p][MBANK_W-1:0]) mrgnt[p] = 1'b0;
         end
      end
   end

   always_comb begin
      grp_ready = '0;
      for (int g = 0; g < MASK_BANK_COUNT; g++)
         grp_ready[g] = (slot_v[2*g] || !bus.REN[2*g]) && (slot_v[2*g+1] || !bus.REN[2*g+1]) &&
                        (mslot_v[g] || !bus.MREN[g]) && (bus.REN[2*g] || bus.REN[2*g+1] || bus.MREN[g]);
   end

   assign bus.ivalid = grp_ready & {MASK_BANK_COUNT{bus.iready}};
   assign bus.vreg   = slot;
   assign bus.vmask  = mslot;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         vregs    <= '{default: '0};
         masks    <= '{default: '0};
         wdone    <= '0;
         rdone    <= '0;
         mwdone   <= '0;
         mrdone   <= '0;
         stage_v  <= '0;
         mstage_v <= '0;
         slot_v   <= '0;
         mslot_v  <= '0;
         stage    <= '0;
         mstage   <= '0;
         slot     <= '0;
         mslot    <= '0;
      end else begin
         for (int p = 0; p < WRITE_PORTS; p++)
            if (wgnt[p]) vregs[bus.vd[p]] <= bus.vdata[p];
         for (int p = 0; p < MASK_BANK_COUNT; p++) begin
            if (mwgnt[p]) masks[bus.vmd[p]] <= bus.mvdata[p];
            if (mrgnt[p]) mstage[p] <= masks[bus.vms[p]];
            if (mstage_v[p]) mslot[p] <= mstage[p];
         end
         for (int p = 0; p < READ_PORTS; p++) begin
            if (rgnt[p]) stage[p] <= vregs[bus.vs[p]];
            if (stage_v[p]) slot[p] <= stage[p];
         end
         // read done bits drop on retire so still-enabled requests are fetched again
         wdone    <= (wdone | wgnt) & bus.WEN;
         mwdone   <= (mwdone | mwgnt) & bus.MWEN;
         rdone    <= (rdone | rgnt) & bus.REN & {READ_PORTS{!bus.accomplished}};
         mrdone   <= (mrdone | mrgnt) & bus.MREN & {MASK_BANK_COUNT{!bus.accomplished}};
         stage_v  <= rgnt;
         mstage_v <= mrgnt;
         slot_v   <= bus.accomplished ? '0 : slot_v | stage_v;
         mslot_v  <= bus.accomplished ? '0 : mslot_v | mstage_v;
      end
   end
endmodule

// File: tb/tb_vector_reg_file.sv
// tb_vector_reg_file: directed write/read-back vectors plus hand-built retire, bypass and reset sequences.
module tb_vector_reg_file;
   typedef struct {
      string             name;
      logic [3:0]        wen;
      logic [3:0][7:0]   vd;
      logic [3:0]        wones;
      logic [1:0]        mwen;
      logic [1:0][3:0]   vmd;
      logic [1:0][31:0]  mdata;
      int                wcyc;
      logic [3:0]        ren;
      logic [3:0][7:0]   vs;
      logic [1:0]        mren;
      logic [1:0][3:0]   vms;
      int                rlat;
      logic [1:0]        eiv;
      logic [3:0]        eones;
      logic [1:0][31:0]  emask;
   } vec_t;

   logic  CLK = 1'b0;
   logic  nRST = 1'b1;
   int    n_vec = 0;
   int    n_miss = 0;
   vec_t  vt [4];

   vector_reg_file_if bus ();
   vector_reg_file dut (.CLK(CLK), .nRST(nRST), .bus(bus));

   always #5 CLK = ~CLK;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, n_vec=%0d required completion", n_vec);
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic idle();
      bus.REN = '0; bus.vs = '0; bus.WEN = '0; bus.vd = '0; bus.vdata = '0;
      bus.MREN = '0; bus.vms = '0; bus.MWEN = '0; bus.vmd = '0; bus.mvdata = '0;
      bus.accomplished = 1'b0;
   endtask

   task automatic pulse_acc(input string nm);
      bus.accomplished = 1'b1;
      @(negedge CLK);
      bus.accomplished = 1'b0;
      chk({nm, ".acc_ivalid"}, 512'(bus.ivalid), '0);
   endtask

   initial begin
      vt[0] = '{"full", 4'b1111, {8'h0B, 8'h0A, 8'h09, 8'h08}, 4'b0101,
                2'b11, {4'h1, 4'h0}, {32'h0, 32'hFFFFFFFF}, 1,
                4'b1111, {8'h0B, 8'h0A, 8'h09, 8'h08}, 2'b11, {4'h1, 4'h0},
                2, 2'b11, 4'b0101, {32'h0, 32'hFFFFFFFF}};
      vt[1] = '{"conflict", 4'b1111, {8'h0C, 8'h08, 8'h04, 8'h00}, 4'b1011,
                2'b11, {4'h4, 4'h2}, {32'hCAFEF00D, 32'hCAFEBABE}, 4,
                4'b1111, {8'h0C, 8'h08, 8'h04, 8'h00}, 2'b11, {4'h4, 4'h2},
                5, 2'b11, 4'b1011, {32'hCAFEF00D, 32'hCAFEBABE}};
      vt[2] = '{"half", 4'b0011, {8'h00, 8'h00, 8'h02, 8'h01}, 4'b0001,
                2'b01, {4'h0, 4'h0}, {32'h0, 32'hA5A5A5A5}, 1,
                4'b0011, {8'h00, 8'h00, 8'h02, 8'h01}, 2'b01, {4'h0, 4'h0},
                2, 2'b01, 4'b1001, {32'hCAFEF00D, 32'hA5A5A5A5}};
      vt[3] = '{"half_conflict", 4'b0011, {8'h00, 8'h00, 8'h04, 8'h00}, 4'b0000,
                2'b01, {4'h0, 4'h2}, {32'h0, 32'hDEADBEEF}, 2,
                4'b0011, {8'h00, 8'h00, 8'h04, 8'h00}, 2'b01, {4'h0, 4'h2},
                3, 2'b01, 4'b1000, {32'hCAFEF00D, 32'hDEADBEEF}};
      idle();
      bus.iready = 1'b1;
      #1 nRST = 1'b0;
      repeat (2) @(negedge CLK);
      chk("rst.ivalid", 512'(bus.ivalid), '0);
      for (int p = 0; p < 4; p++) chk($sformatf("rst.vreg%0d", p), bus.vreg[p], '0);
      for (int m = 0; m < 2; m++) chk($sformatf("rst.vmask%0d", m), 512'(bus.vmask[m]), '0);
      nRST = 1'b1;
      @(negedge CLK);

      for (int i = 0; i < 4; i++) begin
         bus.WEN = vt[i].wen; bus.vd = vt[i].vd;
         for (int p = 0; p < 4; p++) bus.vdata[p] = {512{vt[i].wones[p]}};
         bus.MWEN = vt[i].mwen; bus.vmd = vt[i].vmd; bus.mvdata = vt[i].mdata;
         repeat (vt[i].wcyc) @(posedge CLK);
         @(negedge CLK);
         bus.WEN = '0; bus.MWEN = '0;
         bus.REN = vt[i].ren; bus.vs = vt[i].vs; bus.MREN = vt[i].mren; bus.vms = vt[i].vms;
         for (int k = 1; k <= vt[i].rlat; k++) begin
            @(negedge CLK);
            if (k == vt[i].rlat - 1)
               chk({vt[i].name, ".early"}, 512'((bus.ivalid & vt[i].eiv) == vt[i].eiv), '0);
         end
         chk({vt[i].name, ".ivalid"}, 512'(bus.ivalid), 512'(vt[i].eiv));
         for (int p = 0; p < 4; p++)
            chk($sformatf("%s.vreg%0d", vt[i].name, p), bus.vreg[p], {512{vt[i].eones[p]}});
         for (int m = 0; m < 2; m++)
            chk($sformatf("%s.vmask%0d", vt[i].name, m), 512'(bus.vmask[m]), 512'(vt[i].emask[m]));
         pulse_acc(vt[i].name);
         bus.REN = '0; bus.MREN = '0;
      end

      // consumer stalled: operands buffer up but no group is offered
      bus.iready = 1'b0;
      bus.REN = 4'b1111; bus.vs = {8'h0B, 8'h0A, 8'h09, 8'h08};
      bus.MREN = 2'b11; bus.vms = {4'h1, 4'h0};
      repeat (3) @(negedge CLK);
      chk("stall.ivalid", 512'(bus.ivalid), '0);
      chk("stall.vreg2", bus.vreg[2], '1);
      chk("stall.vmask0", 512'(bus.vmask[0]), 512'(32'hA5A5A5A5));
      bus.iready = 1'b1;
      #1 chk("stall.release", 512'(bus.ivalid), 512'(2'b11));
      pulse_acc("stall");
      bus.REN = '0; bus.MREN = '0;

      // same-cycle read and write of 0x0A sees the old value; retire forces a re-read
      bus.REN = 4'b0001; bus.vs[0] = 8'h0A;
      bus.WEN = 4'b0001; bus.vd[0] = 8'h0A; bus.vdata[0] = '0;
      @(negedge CLK);
      bus.WEN = '0;
      @(negedge CLK);
      chk("rw.ivalid", 512'(bus.ivalid), 512'(2'b01));
      chk("rw.old", bus.vreg[0], '1);
      pulse_acc("rw");
      repeat (2) @(negedge CLK);
      chk("rw.reread", bus.vreg[0], '0);
      chk("rw.ivalid2", 512'(bus.ivalid), 512'(2'b01));
      bus.REN = '0;
      @(negedge CLK);

      // reset in the middle of a same-bank write burst
      bus.WEN = 4'b1111; bus.vd = {8'h0C, 8'h08, 8'h04, 8'h00};
      for (int p = 0; p < 4; p++) bus.vdata[p] = '1;
      @(negedge CLK);
      nRST = 1'b0;
      #1;
      chk("mid_rst.ivalid", 512'(bus.ivalid), '0);
      chk("mid_rst.vmask0", 512'(bus.vmask[0]), '0);
      bus.WEN = '0;
      @(negedge CLK);
      nRST = 1'b1;
      bus.REN = 4'b1111; bus.vs = {8'h0C, 8'h08, 8'h04, 8'h00};
      bus.MREN = 2'b11; bus.vms = {4'h4, 4'h2};
      repeat (5) @(negedge CLK);
      chk("post_rst.ivalid", 512'(bus.ivalid), 512'(2'b11));
      for (int p = 0; p < 4; p++) chk($sformatf("post_rst.vreg%0d", p), bus.vreg[p], '0);
      for (int m = 0; m < 2; m++) chk($sformatf("post_rst.vmask%0d", m), 512'(bus.vmask[m]), '0);
      idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
